// File: rtl/mem_loader_pkg.sv
// Shared types and constants for the boot/program loader that writes the
// instruction/data RAM through its dado/endereco/write port.
package mem_loader_pkg;

    localparam int ADDR_W_DEF = 10;
    localparam int DATA_W_DEF = 32;
    localparam int DEPTH_DEF  = 512;

    // Same encoding as the control unit's hlt opcode
    localparam logic [5:0] OP_HLT = 6'b010010;

    typedef enum logic [1:0] {
        IDLE,
        RECV,
        WRITE,
        FIN
    } state_e;

    function automatic logic is_hlt(input logic [31:0] word);
        return word[31:26] == OP_HLT;
    endfunction

endpackage

// File: rtl/mem_loader_byte_packer.sv
// Packs a byte stream MSB first into 32-bit words; word_valid_o flags the
// cycle in which the fourth byte of a word is being accepted.
module mem_loader_byte_packer
    import mem_loader_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        clear_i,
    input  logic        shift_i,
    input  logic [7:0]  byte_i,
    output logic [31:0] word_o,
    output logic        word_valid_o
);

    logic [23:0] shift_q;
    logic [23:0] shift_d;
    logic [1:0]  cnt_q;
    logic [1:0]  cnt_d;

    always_comb begin
        shift_d = shift_q;
        cnt_d   = cnt_q;
        if (clear_i) begin
            shift_d = '0;
            cnt_d   = '0;
        end else if (shift_i) begin
            shift_d = {shift_q[15:0], byte_i};
            cnt_d   = cnt_q + 2'd1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            shift_q <= '0;
            cnt_q   <= '0;
        end else begin
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
        end
    end

    // Only three bytes are stored; the fourth is taken straight from the input
    assign word_o       = {shift_q, byte_i};
    assign word_valid_o = shift_i && (cnt_q == 2'd3);

endmodule

// File: rtl/mem_loader.sv
// Program loader: receives bytes over valid/ready, packs them into words and
// writes them to consecutive RAM addresses while holding busy high.
module mem_loader
    import mem_loader_pkg::*;
#(
    parameter int ADDR_W      = ADDR_W_DEF,
    parameter int DATA_W      = DATA_W_DEF,
    parameter int DEPTH       = DEPTH_DEF,
    parameter bit STOP_ON_HLT = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W:0]   word_count,
    input  logic [7:0]        byte_in,
    input  logic              byte_valid,
    output logic              byte_ready,
    output logic [DATA_W-1:0] dado,
    output logic [ADDR_W-1:0] endereco,
    output logic              write,
    output logic              busy,
    output logic              done,
    output logic              error
);

    localparam logic [ADDR_W:0] DEPTH_LIM = (ADDR_W+1)'(DEPTH);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W:0]   remaining_q, remaining_d;
    logic [DATA_W-1:0] dado_q, dado_d;
    logic [ADDR_W-1:0] endereco_q, endereco_d;
    logic              write_q, write_d;
    logic              byteReady_q, byteReady_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              error_q, error_d;

    logic              packClear;
    logic              byteFire;
    logic [31:0]       packWord;
    logic              packValid;
    logic [ADDR_W:0]   rangeSum;

    assign byteFire = byte_valid && byteReady_q;
    assign rangeSum = {1'b0, base_addr} + word_count;

    mem_loader_byte_packer u_packer (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .clear_i      (packClear),
        .shift_i      (byteFire),
        .byte_i       (byte_in),
        .word_o       (packWord),
        .word_valid_o (packValid)
    );

    // Outputs are computed one cycle ahead so every port comes from a flop
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        remaining_d = remaining_q;
        dado_d      = dado_q;
        endereco_d  = endereco_q;
        write_d     = 1'b0;
        byteReady_d = 1'b0;
        busy_d      = busy_q;
        done_d      = 1'b0;
        error_d     = error_q;
        packClear   = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    addr_d      = base_addr;
                    remaining_d = word_count;
                    error_d     = 1'b0;
                    busy_d      = 1'b1;
                    packClear   = 1'b1;
                    if (word_count == '0) begin
                        state_d = FIN;
                        done_d  = 1'b1;
                    end else if (rangeSum > DEPTH_LIM) begin
                        error_d = 1'b1;
                        state_d = FIN;
                        done_d  = 1'b1;
                    end else begin
                        state_d     = RECV;
                        byteReady_d = 1'b1;
                    end
                end
            end
            RECV: begin
                byteReady_d = 1'b1;
                if (packValid) begin
                    state_d     = WRITE;
                    byteReady_d = 1'b0;
                    write_d     = 1'b1;
                    dado_d      = packWord;
                    endereco_d  = addr_q;
                end
            end
            WRITE: begin
                addr_d      = addr_q + ADDR_W'(1);
                remaining_d = remaining_q - (ADDR_W+1)'(1);
                if (remaining_q == (ADDR_W+1)'(1) || (STOP_ON_HLT && is_hlt(dado_q))) begin
                    state_d = FIN;
                    done_d  = 1'b1;
                end else begin
                    state_d     = RECV;
                    byteReady_d = 1'b1;
                end
            end
            FIN: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            remaining_q <= '0;
            dado_q      <= '0;
            endereco_q  <= '0;
            write_q     <= 1'b0;
            byteReady_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            remaining_q <= remaining_d;
            dado_q      <= dado_d;
            endereco_q  <= endereco_d;
            write_q     <= write_d;
            byteReady_q <= byteReady_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            error_q     <= error_d;
        end
    end

    assign byte_ready = byteReady_q;
    assign dado       = dado_q;
    assign endereco   = endereco_q;
    assign write      = write_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign error      = error_q;

endmodule

// File: tb/tb_mem_loader.sv
// Directed self-checking bench for mem_loader; RAM writes are captured by a
// negedge monitor and compared against hand-computed addresses and words.
module tb_mem_loader;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [9:0]  base_addr;
    logic [10:0] word_count;
    logic [7:0]  byte_in;
    logic        byte_valid;
    logic        byte_ready;
    logic [31:0] dado;
    logic [9:0]  endereco;
    logic        write;
    logic        busy;
    logic        done;
    logic        error;

    int checks = 0;
    int errors = 0;
    int cycleCnt = 0;
    int readyInWrite = 0;

    logic [9:0]  wrAddr[$];
    logic [31:0] wrData[$];
    int          wrCycle[$];

    logic [7:0]  stim[0:31];
    int          fireCycle[0:31];

    mem_loader dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .base_addr  (base_addr),
        .word_count (word_count),
        .byte_in    (byte_in),
        .byte_valid (byte_valid),
        .byte_ready (byte_ready),
        .dado       (dado),
        .endereco   (endereco),
        .write      (write),
        .busy       (busy),
        .done       (done),
        .error      (error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cycleCnt <= cycleCnt + 1;

    always @(negedge clk) begin
        if (write) begin
            wrAddr.push_back(endereco);
            wrData.push_back(dado);
            wrCycle.push_back(cycleCnt);
        end
        if (write && byte_ready) readyInWrite++;
    end

    task automatic clear_log();
        wrAddr.delete();
        wrData.delete();
        wrCycle.delete();
        readyInWrite = 0;
    endtask

    task automatic set_word(input int slot, input logic [31:0] w);
        stim[slot*4+0] = w[31:24];
        stim[slot*4+1] = w[23:16];
        stim[slot*4+2] = w[15:8];
        stim[slot*4+3] = w[7:0];
    endtask

    task automatic pulse_start(input logic [9:0] base, input logic [10:0] cnt);
        start      = 1'b1;
        base_addr  = base;
        word_count = cnt;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // Offers stim[first +: n]; a byte moves only on cycles where the DUT is ready
    task automatic send_stream(input int first, input int n, input bit toggle);
        int  idx = first;
        int  cyc = 0;
        bit  offCycle = 1'b0;
        bit  fire;
        while (idx < first + n && cyc < 200) begin
            if (toggle && offCycle) begin
                byte_valid = 1'b0;
            end else begin
                byte_valid = 1'b1;
                byte_in    = stim[idx];
            end
            fire = byte_valid && byte_ready;
            @(posedge clk); #1;
            if (fire) begin
                fireCycle[idx] = cycleCnt;
                idx++;
            end
            offCycle = !offCycle;
            cyc++;
        end
        byte_valid = 1'b0;
        checks++;
        if (idx != first + n) begin
            errors++;
            $display("[TB] FAIL send_stream: accepted %0d bytes, expected %0d", idx - first, n);
        end
    endtask

    task automatic wait_done(input string tag);
        bit seen = 1'b0;
        for (int i = 0; i < 100 && !seen; i++) begin
            if (done) seen = 1'b1;
            else begin
                @(posedge clk); #1;
            end
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("[TB] FAIL %s_done: got no done pulse, expected one within 100 cycles", tag);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; base_addr = '0; word_count = '0;
        byte_in = '0; byte_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({byte_ready, write, busy, done, error} !== 5'b0) begin
            errors++;
            $display("[TB] FAIL reset_flags: got %b, expected 00000", {byte_ready, write, busy, done, error});
        end
        checks++;
        if (dado !== 32'h0 || endereco !== 10'h0) begin
            errors++;
            $display("[TB] FAIL reset_bus: got dado=%h addr=%h, expected 0/0", dado, endereco);
        end
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        byte_valid = 1'b1;
        byte_in    = 8'hAA;
        repeat (3) begin
            @(posedge clk); #1;
        end
        byte_valid = 1'b0;
        checks++;
        if (byte_ready !== 1'b0 || busy !== 1'b0 || wrAddr.size() != 0) begin
            errors++;
            $display("[TB] FAIL idle_no_accept: got ready=%b busy=%b writes=%0d, expected 0/0/0",
                     byte_ready, busy, wrAddr.size());
        end
    endtask

    task automatic test_normal_load(input bit toggle, input string tag);
        clear_log();
        set_word(0, 32'h04000014);
        set_word(1, 32'h58000000);
        pulse_start(10'd0, 11'd2);
        checks++;
        if (busy !== 1'b1 || byte_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL %s_start: got busy=%b ready=%b, expected 1/1", tag, busy, byte_ready);
        end
        send_stream(0, 8, toggle);
        wait_done(tag);
        checks++;
        if (wrAddr.size() != 2) begin
            errors++;
            $display("[TB] FAIL %s_count: got %0d writes, expected 2", tag, wrAddr.size());
        end else begin
            checks++;
            if (wrAddr[0] !== 10'd0 || wrData[0] !== 32'h04000014) begin
                errors++;
                $display("[TB] FAIL %s_w0: got (%0d,%h), expected (0,04000014)", tag, wrAddr[0], wrData[0]);
            end
            checks++;
            if (wrAddr[1] !== 10'd1 || wrData[1] !== 32'h58000000) begin
                errors++;
                $display("[TB] FAIL %s_w1: got (%0d,%h), expected (1,58000000)", tag, wrAddr[1], wrData[1]);
            end
            checks++;
            if (wrCycle[0] != fireCycle[3] || wrCycle[1] != fireCycle[7]) begin
                errors++;
                $display("[TB] FAIL %s_latency: got write cycles %0d,%0d, expected %0d,%0d",
                         tag, wrCycle[0], wrCycle[1], fireCycle[3], fireCycle[7]);
            end
            if (!toggle) begin
                checks++;
                if (wrCycle[1] - wrCycle[0] != 5) begin
                    errors++;
                    $display("[TB] FAIL %s_rate: got spacing %0d, expected 5", tag, wrCycle[1] - wrCycle[0]);
                end
            end
        end
        checks++;
        if (readyInWrite != 0) begin
            errors++;
            $display("[TB] FAIL %s_ready_in_write: got %0d cycles, expected 0", tag, readyInWrite);
        end
        @(posedge clk); #1;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("[TB] FAIL %s_end: got busy=%b done=%b, expected 0/0", tag, busy, done);
        end
    endtask

    task automatic test_hlt();
        clear_log();
        set_word(0, 32'h04000014);
        set_word(1, 32'h48000000);
        pulse_start(10'd0, 11'd5);
        send_stream(0, 8, 1'b0);
        wait_done("hlt");
        @(posedge clk); #1;
        byte_valid = 1'b1;
        byte_in    = 8'h11;
        repeat (4) begin
            checks++;
            if (byte_ready !== 1'b0) begin
                errors++;
                $display("[TB] FAIL hlt_no_request: got ready=%b, expected 0", byte_ready);
            end
            @(posedge clk); #1;
        end
        byte_valid = 1'b0;
        checks++;
        if (wrAddr.size() != 2) begin
            errors++;
            $display("[TB] FAIL hlt_count: got %0d writes, expected 2", wrAddr.size());
        end else begin
            checks++;
            if (wrAddr[1] !== 10'd1 || wrData[1] !== 32'h48000000) begin
                errors++;
                $display("[TB] FAIL hlt_w1: got (%0d,%h), expected (1,48000000)", wrAddr[1], wrData[1]);
            end
        end
        checks++;
        if (busy !== 1'b0 || error !== 1'b0) begin
            errors++;
            $display("[TB] FAIL hlt_end: got busy=%b error=%b, expected 0/0", busy, error);
        end
    endtask

    task automatic test_range_error();
        clear_log();
        pulse_start(10'd510, 11'd3);
        checks++;
        if (done !== 1'b1 || error !== 1'b1 || busy !== 1'b1) begin
            errors++;
            $display("[TB] FAIL range_fin: got done=%b error=%b busy=%b, expected 1/1/1", done, error, busy);
        end
        repeat (2) begin
            @(posedge clk); #1;
        end
        checks++;
        if (done !== 1'b0 || busy !== 1'b0 || error !== 1'b1) begin
            errors++;
            $display("[TB] FAIL range_sticky: got done=%b busy=%b error=%b, expected 0/0/1", done, busy, error);
        end
        checks++;
        if (wrAddr.size() != 0) begin
            errors++;
            $display("[TB] FAIL range_writes: got %0d writes, expected 0", wrAddr.size());
        end
        set_word(0, 32'hA1B2C3D4);
        pulse_start(10'd511, 11'd1);
        checks++;
        if (error !== 1'b0 || byte_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL range_clear: got error=%b ready=%b, expected 0/1", error, byte_ready);
        end
        send_stream(0, 4, 1'b0);
        wait_done("last_addr");
        checks++;
        if (wrAddr.size() != 1 || wrAddr[0] !== 10'd511 || wrData[0] !== 32'hA1B2C3D4) begin
            errors++;
            $display("[TB] FAIL last_addr_write: got %0d writes first=(%0d,%h), expected 1 (511,a1b2c3d4)",
                     wrAddr.size(), (wrAddr.size() > 0) ? wrAddr[0] : 10'd0,
                     (wrData.size() > 0) ? wrData[0] : 32'd0);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_zero_and_ignored_start();
        clear_log();
        pulse_start(10'd7, 11'd0);
        checks++;
        if (done !== 1'b1 || error !== 1'b0) begin
            errors++;
            $display("[TB] FAIL zero_done: got done=%b error=%b, expected 1/0", done, error);
        end
        repeat (3) begin
            @(posedge clk); #1;
        end
        checks++;
        if (wrAddr.size() != 0 || busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL zero_idle: got writes=%0d busy=%b, expected 0/0", wrAddr.size(), busy);
        end
        set_word(0, 32'h11223344);
        set_word(1, 32'h55667788);
        pulse_start(10'd20, 11'd2);
        send_stream(0, 2, 1'b0);
        pulse_start(10'd300, 11'd7);
        send_stream(2, 6, 1'b0);
        wait_done("ignored");
        checks++;
        if (wrAddr.size() != 2) begin
            errors++;
            $display("[TB] FAIL ignored_count: got %0d writes, expected 2", wrAddr.size());
        end else begin
            checks++;
            if (wrAddr[0] !== 10'd20 || wrData[0] !== 32'h11223344 ||
                wrAddr[1] !== 10'd21 || wrData[1] !== 32'h55667788) begin
                errors++;
                $display("[TB] FAIL ignored_writes: got (%0d,%h) (%0d,%h), expected (20,11223344) (21,55667788)",
                         wrAddr[0], wrData[0], wrAddr[1], wrData[1]);
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid();
        clear_log();
        set_word(0, 32'h0A0B0C0D);
        set_word(1, 32'h01020304);
        set_word(2, 32'hDEADBEEF);
        pulse_start(10'd40, 11'd4);
        send_stream(0, 10, 1'b0);
        rst_n = 1'b0;
        #1;
        checks++;
        if ({byte_ready, write, busy, done, error} !== 5'b0 || dado !== 32'h0 || endereco !== 10'h0) begin
            errors++;
            $display("[TB] FAIL mid_reset_outputs: got flags=%b dado=%h addr=%h, expected 0",
                     {byte_ready, write, busy, done, error}, dado, endereco);
        end
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (wrAddr.size() != 2) begin
            errors++;
            $display("[TB] FAIL mid_reset_writes: got %0d writes, expected 2", wrAddr.size());
        end
        clear_log();
        set_word(0, 32'hCAFEF00D);
        pulse_start(10'd100, 11'd1);
        send_stream(0, 4, 1'b0);
        wait_done("reload");
        checks++;
        if (wrAddr.size() != 1 || wrAddr[0] !== 10'd100 || wrData[0] !== 32'hCAFEF00D) begin
            errors++;
            $display("[TB] FAIL reload_write: got %0d writes first=(%0d,%h), expected 1 (100,cafef00d)",
                     wrAddr.size(), (wrAddr.size() > 0) ? wrAddr[0] : 10'd0,
                     (wrData.size() > 0) ? wrData[0] : 32'd0);
        end
    endtask

    initial begin
        test_reset();
        test_normal_load(1'b0, "normal");
        test_normal_load(1'b1, "backpressure");
        test_hlt();
        test_range_error();
        test_zero_and_ignored_start();
        test_reset_mid();
        repeat (2) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_loader.md
Name: mem_loader

Overview:
- Boot/program loader: the writer side of the instruction/data RAM port (dado, endereco, write).
- Accepts a byte stream over a valid/ready handshake and packs 4 bytes, MSB first, into 32-bit words.
- Writes each word into consecutive RAM addresses, starting at a programmed base.
- Holds `busy` high while loading so the CPU is kept out of the memory port until `done`.

Parameters:
- ADDR_W, 10, width of the memory address (endereco).
- DATA_W, 32, memory word width; fixed at 4 bytes.
- DEPTH, 512, number of implemented RAM words; last legal address is DEPTH-1.
- STOP_ON_HLT, 1, when 1, loading ends after writing a word whose opcode [31:26] = 6'b010010 (hlt).

Ports:
- clk  in  1  single clock; the memory write clock is the same net.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse; begins a load when idle.
- base_addr  in  ADDR_W  first write address, sampled on start.
- word_count  in  ADDR_W+1  number of words to load, sampled on start.
- byte_in  in  8  stream byte.
- byte_valid  in  1  byte_in is valid.
- byte_ready  out  1  loader accepts a byte this cycle.
- dado  out  DATA_W  write data to RAM.
- endereco  out  ADDR_W  write address to RAM.
- write  out  1  RAM write enable; high for exactly one clk per word.
- busy  out  1  load in progress.
- done  out  1  one-cycle pulse at the end of a load (normal, hlt or error).
- error  out  1  sticky; set when a load would exceed DEPTH-1; cleared by the next start.

Behaviour:
- Reset (asynchronous, rst_n=0): state IDLE; byte_ready, write, busy, done, error = 0; dado = 0; endereco = 0; byte and word counters = 0.
- All outputs are registered. dado/endereco/write change only at posedge clk, giving the RAM a full cycle of setup before its sampling edge.
- FSM states:
  - IDLE: byte_ready=0. On start:
    - latch base_addr into addr and word_count into remaining; clear error; busy=1.
    - If word_count=0: go to FIN.
    - Else if base_addr+word_count > DEPTH: set error and go to FIN.
    - Else go to RECV.
  - RECV: byte_ready=1. A byte transfers when byte_valid && byte_ready. It is shifted into a 32-bit assembly register (shift left 8, byte into [7:0]) and byte_cnt increments mod 4. On the 4th byte, go to WRITE and deassert byte_ready in the next cycle.
  - WRITE: for one cycle write=1, dado=assembled word, endereco=addr; byte_ready=0. Next cycle:
    - addr+1, remaining-1.
    - If remaining becomes 0, or (STOP_ON_HLT and dado[31:26]=6'b010010): go to FIN.
    - Else return to RECV.
  - FIN: done=1 for one cycle; busy=0 from the next cycle; return to IDLE.
- Latency: 4th byte accepted at edge N gives write=1 during cycle N+1. Peak throughput is 1 word per 5 cycles.
- start while busy: ignored.
- byte_valid while not in RECV: no transfer, and the byte is not consumed.
- Address arithmetic uses ADDR_W+1 bits for the range check. addr never wraps, because the range check happens up front.
- Reset mid-load: partial words are discarded, any in-progress write is aborted immediately, and words already written remain in RAM.
- error stays high through FIN and IDLE until the next start.

Decomposition:
- Shared package:
  - FSM state enum (IDLE, RECV, WRITE, FIN).
  - Opcode constant OP_HLT = 6'b010010, shared with the control unit's opcode list.
  - Default ADDR_W/DEPTH constants.
- One natural sub-module: byte_packer. It holds the 8→32 shift register and the mod-4 counter, and exposes word_valid/clear. The top level holds the FSM, address and counters.

Test Plan:
- Normal load: start, base_addr=0, word_count=2; bytes 04,00,00,14, 58,00,00,00 → write pulses with (0, 0x04000014), then (1, 0x58000000); then done; busy=0.
- Back-pressure: same load with byte_valid toggling every other cycle → identical writes. byte_ready is 0 in each WRITE cycle; no byte is lost or duplicated.
- hlt stop: STOP_ON_HLT=1, word_count=5, second word 0x48000000 → exactly 2 writes (addr 0,1), then done; remaining words are not requested.
- Range error: base_addr=510, word_count=3 → error=1, done pulse, zero writes. A following start with word_count=1 clears error.
- Zero count / ignored start: word_count=0 → done on the cycle after start and no writes. A start pulse mid-load leaves addresses and counts unchanged.
- Reset mid-operation: assert rst_n=0 after 2 bytes of word 3 → all outputs 0 immediately, no write. A new load from base 100 writes correctly starting at 100.
